// File: rtl/tcam_match_serializer.sv
// Match-array post-processor: captures a per-entry match vector, reports hit/first/count,
// then streams each matching index in ascending order over a valid/ready handshake.
module tcam_match_serializer #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int CNT_W   = $clog2(ENTRIES + 1)
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               start_i,
    input  logic [ENTRIES-1:0] match_vec_i,
    output logic               busy_o,
    output logic               hit_o,
    output logic [IDX_W-1:0]   first_idx_o,
    output logic [CNT_W-1:0]   match_cnt_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [IDX_W-1:0]   out_idx_o,
    output logic               out_last_o,
    output logic               done_o
);

    typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;

    state_t             state_q, state_d;
    logic [ENTRIES-1:0] pending_q, pending_d;
    logic               hit_q, hit_d;
    logic [IDX_W-1:0]   first_q, first_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               accept;
    logic               xfer;
    logic               pend_last;
    logic [IDX_W-1:0]   pend_idx;

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [ENTRIES-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [ENTRIES-1:0] v);
        logic [CNT_W-1:0] r;
        r = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            r = r + CNT_W'(v[i]);
        end
        return r;
    endfunction

    assign accept    = (state_q == IDLE) && start_i;
    assign xfer      = (state_q == SCAN) && out_ready_i;
    assign pend_idx  = lowest_idx(pending_q);
    // Exactly one bit set: clearing the lowest set bit leaves nothing behind.
    assign pend_last = (pending_q != '0) && ((pending_q & (pending_q - ENTRIES'(1))) == '0);

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            pending_q <= '0;
            hit_q     <= 1'b0;
            first_q   <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            hit_q     <= hit_d;
            first_q   <= first_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        hit_d     = hit_q;
        first_d   = first_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    pending_d = match_vec_i;
                    hit_d     = (match_vec_i != '0);
                    first_d   = lowest_idx(match_vec_i);
                    cnt_d     = popcount(match_vec_i);
                    state_d   = (match_vec_i != '0) ? SCAN : FIN;
                end
            end
            SCAN: begin
                if (xfer) begin
                    pending_d = pending_q & (pending_q - ENTRIES'(1));
                    if (pend_last) state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy_o      = (state_q != IDLE);
        out_valid_o = (state_q == SCAN);
        out_idx_o   = (state_q == SCAN) ? pend_idx : '0;
        out_last_o  = (state_q == SCAN) && pend_last;
        done_o      = (state_q == FIN);
        hit_o       = hit_q;
        first_idx_o = first_q;
        match_cnt_o = cnt_q;
    end

endmodule

// File: tb/tb_tcam_match_serializer.sv
// Randomized bench for tcam_match_serializer; expectations come from a queue of
// matching indices built directly from each captured vector.
module tb_tcam_match_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] vec;
    logic        busy, hit, out_valid, ready, out_last, done;
    logic [3:0]  first_idx, out_idx;
    logic [4:0]  match_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tcam_match_serializer dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .match_vec_i(vec),
        .busy_o(busy), .hit_o(hit), .first_idx_o(first_idx), .match_cnt_o(match_cnt),
        .out_valid_o(out_valid), .out_ready_i(ready), .out_idx_o(out_idx),
        .out_last_o(out_last), .done_o(done)
    );

    // Runs one scan of v. mode: 0 ready held 1, 1 random ready, 2 ready low for 3 cycles.
    // inject drives random start pulses and vector noise while the scan is busy.
    task automatic do_scan(input logic [15:0] v, input int mode, input bit inject, input string nm);
        int  q[$];
        int  ecnt, efirst, cyc;
        bit  fin_seen;
        for (int i = 0; i < 16; i++) if (v[i]) q.push_back(i);
        ecnt   = q.size();
        efirst = (ecnt > 0) ? q[0] : 0;
        start = 1'b1; vec = v;
        @(posedge clk); #1;
        start = 1'b0; vec = 16'($urandom);
        cyc = 0; fin_seen = 1'b0;
        while (!fin_seen && cyc < 200) begin
            case (mode)
                0:       ready = 1'b1;
                1:       ready = 1'($urandom_range(0, 1));
                default: ready = (cyc < 3) ? 1'b0 : 1'b1;
            endcase
            if (inject) begin start = 1'($urandom_range(0, 1)); vec = 16'($urandom); end
            @(negedge clk);
            n_cmp++; if (hit !== (ecnt != 0)) begin n_err++; $display("FAIL %s hit: got %b want %b", nm, hit, ecnt != 0); end
            n_cmp++; if (match_cnt !== 5'(ecnt)) begin n_err++; $display("FAIL %s cnt: got %0d want %0d", nm, match_cnt, ecnt); end
            n_cmp++; if (first_idx !== 4'(efirst)) begin n_err++; $display("FAIL %s first: got %0d want %0d", nm, first_idx, efirst); end
            n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL %s busy: got %b want 1 (cyc %0d)", nm, busy, cyc); end
            if (q.size() > 0) begin
                n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL %s valid: got %b want 1 (cyc %0d)", nm, out_valid, cyc); end
                n_cmp++; if (out_idx !== 4'(q[0])) begin n_err++; $display("FAIL %s idx: got %0d want %0d (cyc %0d)", nm, out_idx, q[0], cyc); end
                n_cmp++; if (out_last !== (q.size() == 1)) begin n_err++; $display("FAIL %s last: got %b want %b (cyc %0d)", nm, out_last, q.size() == 1, cyc); end
                n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL %s early done: got %b want 0 (cyc %0d)", nm, done, cyc); end
            end else begin
                n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL %s done: got %b want 1 (cyc %0d)", nm, done, cyc); end
                n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL %s valid in fin: got %b want 0", nm, out_valid); end
                fin_seen = 1'b1;
            end
            @(posedge clk); #1;
            if (q.size() > 0 && ready) void'(q.pop_front());
            cyc++;
        end
        start = 1'b0; ready = 1'b0;
        if (!fin_seen) begin n_cmp++; n_err++; $display("FAIL %s timeout: got no done want done within 200 cycles", nm); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL %s idle: got busy %b done %b want 0 0", nm, busy, done); end
        n_cmp++; if (match_cnt !== 5'(ecnt) || hit !== (ecnt != 0)) begin n_err++; $display("FAIL %s hold: got cnt %0d hit %b want %0d %b", nm, match_cnt, hit, ecnt, ecnt != 0); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; vec = '0; ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++;
        if ({busy, hit, first_idx, match_cnt, out_valid, out_idx, out_last, done} !== '0) begin
            n_err++;
            $display("FAIL reset outputs: got %b want all zero", {busy, hit, first_idx, match_cnt, out_valid, out_idx, out_last, done});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_zero();      do_scan(16'h0000, 0, 1'b0, "zero");   endtask
    task automatic test_spread();    do_scan(16'h8421, 0, 1'b0, "spread"); endtask
    task automatic test_stall();     do_scan(16'h0006, 2, 1'b0, "stall");  endtask
    task automatic test_busy_start();
        do_scan(16'h0010, 1, 1'b1, "ignore");
        do_scan(16'h0000, 0, 1'b1, "ignore_zero");
    endtask
    task automatic test_full();      do_scan(16'hFFFF, 0, 1'b0, "full");   endtask

    task automatic test_random();
        logic [15:0] v;
        for (int k = 0; k < 30; k++) begin
            case ($urandom_range(0, 5))
                0:       v = 16'h0000;
                1:       v = 16'h0001 << $urandom_range(0, 15);
                2:       v = 16'hFFFF;
                default: v = 16'($urandom);
            endcase
            do_scan(v, 1, 1'($urandom_range(0, 1)), "random");
        end
    endtask

    task automatic test_reset_mid();
        ready = 1'b1; start = 1'b1; vec = 16'h00F0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++; if (out_idx !== 4'd6) begin n_err++; $display("FAIL midrst pre idx: got %0d want 6", out_idx); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if ({busy, hit, first_idx, match_cnt, out_valid, out_idx, out_last, done} !== '0) begin
            n_err++;
            $display("FAIL midrst outputs: got %b want all zero", {busy, hit, first_idx, match_cnt, out_valid, out_idx, out_last, done});
        end
        @(posedge clk); #1;
        rst_n = 1'b1; ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL midrst after: got done %b busy %b want 0 0", done, busy); end
            @(posedge clk); #1;
        end
        do_scan(16'h0A50, 1, 1'b0, "post_reset");
    endtask

    initial begin
        test_reset();
        test_zero();
        test_spread();
        test_stall();
        test_busy_start();
        test_full();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
